// File: rtl/write_buffer_bridge.sv
// Posted-write buffer between the processor memory port and memory_controller.
// Writes are acknowledged on entry and drained in order; reads are serviced only once the buffer is empty.
module write_buffer_bridge #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic                   cpu_write,
  input  logic                   cpu_size,
  input  logic [1:0]             cpu_prot,
  input  logic [1:0]             cpu_trans,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_data_valid,
  output logic                   cpu_abort,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_write,
  output logic                   mem_size,
  output logic [1:0]             mem_prot,
  output logic [1:0]             mem_trans,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_data_valid,
  input  logic                   mem_abort,
  output logic [$clog2(DEPTH):0] buf_count,
  output logic                   write_err,
  output logic                   idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_WAIT = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic              r_fifo_size [DEPTH];
  logic [1:0]        r_fifo_prot [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     w_count_nxt;
  logic              w_req;
  logic              w_enq;
  logic              w_rd_acc;
  logic              w_pop;
  logic              w_issue;
  logic              w_issue_wr;
  logic              w_rd_done;

  // The response cycle itself never accepts, so a request held across it is taken only once.
  assign w_req    = ((cpu_trans == 2'b10) || (cpu_trans == 2'b11)) && !cpu_data_valid;
  assign w_enq    = w_req && cpu_write && (buf_count < FULL);
  assign w_rd_acc = w_req && !cpu_write && (buf_count == {CW{1'b0}}) && (r_state == S_IDLE);

  // Next-state logic: drains take priority over reads.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_issue_wr  = 1'b0;
    w_rd_done   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (buf_count != {CW{1'b0}}) begin
          w_issue     = 1'b1;
          w_issue_wr  = 1'b1;
          w_state_nxt = S_WR_WAIT;
        end else if (w_rd_acc) begin
          w_issue     = 1'b1;
          w_state_nxt = S_RD_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (mem_data_valid) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (mem_data_valid) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_RD_RESP;
        end else begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_RESP: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Occupancy after this cycle's enqueue and pop.
  always_comb begin
    w_count_nxt = buf_count;
    case ({w_enq, w_pop})
      2'b10:   w_count_nxt = buf_count + CW'(1);
      2'b01:   w_count_nxt = buf_count - CW'(1);
      default: w_count_nxt = buf_count;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Entry storage; emptiness is tracked by the pointers, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_addr[r_wptr] <= cpu_addr;
      r_fifo_data[r_wptr] <= cpu_wdata;
      r_fifo_size[r_wptr] <= cpu_size;
      r_fifo_prot[r_wptr] <= cpu_prot;
    end
  end

  // Pointers, occupancy, sticky error and idle flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= {PW{1'b0}};
      r_rptr    <= {PW{1'b0}};
      buf_count <= {CW{1'b0}};
      write_err <= 1'b0;
      idle      <= 1'b1;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      buf_count <= w_count_nxt;
      write_err <= write_err | (w_pop & mem_abort);
      idle      <= (w_count_nxt == {CW{1'b0}}) && (w_state_nxt == S_IDLE);
    end
  end

  // Processor-side response: posted-write ack or read completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata      <= {DATA_W{1'b0}};
      cpu_data_valid <= 1'b0;
      cpu_abort      <= 1'b0;
    end else begin
      cpu_data_valid <= w_enq | w_rd_done;
      cpu_abort      <= w_rd_done & mem_abort;
      if (w_rd_done) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

  // Memory-side request; fields other than mem_trans hold between issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      mem_write <= 1'b0;
      mem_size  <= 1'b0;
      mem_prot  <= 2'b00;
      mem_trans <= 2'b00;
    end else begin
      mem_trans <= w_issue ? 2'b10 : 2'b00;
      if (w_issue && w_issue_wr) begin
        mem_addr  <= r_fifo_addr[r_rptr];
        mem_wdata <= r_fifo_data[r_rptr];
        mem_write <= 1'b1;
        mem_size  <= r_fifo_size[r_rptr];
        mem_prot  <= r_fifo_prot[r_rptr];
      end else if (w_issue) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_write <= 1'b0;
        mem_size  <= cpu_size;
        mem_prot  <= cpu_prot;
      end
    end
  end

endmodule

// File: tb/tb_write_buffer_bridge.sv
// Bench for write_buffer_bridge: a memory responder plus queue-based scoreboards for the
// processor and memory sides, driven by directed scenarios and a randomized phase.
module tb_write_buffer_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_write, cpu_size, cpu_data_valid, cpu_abort;
  logic [1:0]  cpu_prot, cpu_trans;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_size, mem_data_valid, mem_abort;
  logic [1:0]  mem_prot, mem_trans;
  logic [2:0]  buf_count;
  logic        write_err, idle;

  write_buffer_bridge #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
    .cpu_size(cpu_size), .cpu_prot(cpu_prot), .cpu_trans(cpu_trans),
    .cpu_rdata(cpu_rdata), .cpu_data_valid(cpu_data_valid), .cpu_abort(cpu_abort),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_size(mem_size), .mem_prot(mem_prot), .mem_trans(mem_trans),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid), .mem_abort(mem_abort),
    .buf_count(buf_count), .write_err(write_err), .idle(idle)
  );

  typedef struct { bit is_rd; logic [31:0] data; bit abort; } cpu_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; bit wr; logic size; logic [1:0] prot; } mem_exp_t;

  cpu_exp_t    cpu_q[$];
  mem_exp_t    mem_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] tb_mem  [logic [31:0]];
  bit          ref_err = 1'b0;
  int          checks = 0, errors = 0, cyc = 0;
  int          mem_delay = 0, last_dv_cyc = -1, rd_issue_cyc = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory aborts every access in the 0xF000_0000 region.
  function automatic bit is_abort_addr(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Memory responder and memory-side monitor.
  mem_exp_t    m_e;
  logic [31:0] m_addr, m_data, m_rd;
  bit          m_wr, m_ab;
  initial begin
    mem_data_valid = 1'b0;
    mem_abort      = 1'b0;
    mem_rdata      = 32'h0;
    forever begin
      @(negedge clk);
      if (rst && mem_trans == 2'b10) begin
        m_addr = mem_addr;
        m_data = mem_wdata;
        m_wr   = mem_write;
        if (!m_wr) rd_issue_cyc = cyc;
        if (mem_q.size() == 0) begin
          fail_now("mem_unexpected_request");
        end else begin
          m_e = mem_q.pop_front();
          chk("mem_addr", m_addr, m_e.addr);
          chk("mem_write", m_wr, m_e.wr);
          chk("mem_size", mem_size, m_e.size);
          chk("mem_prot", mem_prot, m_e.prot);
          if (m_e.wr) chk("mem_wdata", m_data, m_e.data);
        end
        m_ab = is_abort_addr(m_addr);
        if (m_wr && !m_ab) tb_mem[m_addr] = m_data;
        m_rd = m_ab ? 32'hBAD0_0000 : (tb_mem.exists(m_addr) ? tb_mem[m_addr] : 32'h0);
        repeat (mem_delay) @(posedge clk);
        @(posedge clk); #1;
        mem_data_valid = 1'b1;
        mem_rdata      = m_rd;
        mem_abort      = m_ab;
        last_dv_cyc    = cyc;
        @(posedge clk); #1;
        mem_data_valid = 1'b0;
        mem_abort      = 1'b0;
      end
    end
  end

  // Processor-side monitor.
  cpu_exp_t c_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst && cpu_data_valid) begin
        if (cpu_q.size() == 0) begin
          fail_now("cpu_unexpected_response");
        end else begin
          c_e = cpu_q.pop_front();
          chk("cpu_abort", cpu_abort, c_e.abort);
          if (c_e.is_rd) begin
            chk("cpu_rdata", cpu_rdata, c_e.data);
            chk("rd_latency", cyc - rd_issue_cyc, 2);
          end
        end
      end
    end
  end

  // Issue one request, push its expectations, hold it until the response cycle has passed.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int dv_cyc);
    cpu_exp_t ce;
    mem_exp_t me;
    logic     sz;
    logic [1:0] pr;
    sz = 1'($urandom);
    pr = 2'($urandom);
    me.addr = a; me.data = d; me.wr = wr; me.size = sz; me.prot = pr;
    mem_q.push_back(me);
    ce.is_rd = !wr;
    ce.abort = !wr && is_abort_addr(a);
    ce.data  = 32'h0;
    if (wr) begin
      if (is_abort_addr(a)) ref_err = 1'b1;
      else ref_mem[a] = d;
    end else begin
      ce.data = is_abort_addr(a) ? 32'hBAD0_0000 : (ref_mem.exists(a) ? ref_mem[a] : 32'h0);
    end
    cpu_q.push_back(ce);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = wr;
    cpu_size  = sz;
    cpu_prot  = pr;
    cpu_trans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_data_valid && lat < 200);
    dv_cyc = cyc;
    if (!cpu_data_valid) fail_now("req_timeout");
    @(posedge clk); #1;
    cpu_trans = 2'b00;
  endtask

  // Idle or busy cycles with random junk on the other request fields.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_trans = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cpu_write = 1'($urandom);
      @(posedge clk); #1;
    end
    cpu_trans = 2'b00;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!idle && n < 300);
    chk({nm, "_idle"}, idle, 1);
    chk({nm, "_count0"}, buf_count, 0);
    chk({nm, "_write_err"}, write_err, ref_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  int          lat, dvc, rst_cyc, k;
  logic [31:0] ra;
  initial begin
    rst = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_write = 1'b0;
    cpu_size = 1'b0; cpu_prot = 2'b00; cpu_trans = 2'b00;
    repeat (2) @(posedge clk); #1;
    chk("rst_cpu_data_valid", cpu_data_valid, 0);
    chk("rst_mem_trans", mem_trans, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_write_err", write_err, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single posted write, then read it back.
    do_req(1'b1, 32'h100, 32'hDEADBEEF, lat, dvc);
    chk("t1_wr_latency", lat, 2);
    chk("t1_count1", buf_count, 1);
    wait_idle("t1");
    do_req(1'b0, 32'h100, 32'h0, lat, dvc);
    chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);

    // Fill the buffer behind a slow memory; the fifth write waits for the first pop.
    mem_delay = 20;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 32'(i * 4), $urandom, lat, dvc);
      chk("t2_wr_latency", lat, 2);
    end
    chk("t2_count_full", buf_count, 4);
    do_req(1'b1, 32'h10, $urandom, lat, dvc);
    chk("t2_stall_release", dvc, last_dv_cyc + 2);
    mem_delay = 0;
    wait_idle("t2");

    // Read right behind a write must wait for the drain.
    do_req(1'b1, 32'h200, 32'h11223344, lat, dvc);
    do_req(1'b0, 32'h200, 32'h0, lat, dvc);
    chk("t3_rdata", cpu_rdata, 32'h11223344);

    // Aborted drain sets sticky write_err; aborted read flags cpu_abort.
    do_req(1'b1, 32'hF000_0010, 32'h55AA55AA, lat, dvc);
    wait_idle("t4a");
    chk("t4_write_err_set", write_err, 1);
    do_req(1'b1, 32'h300, 32'h0BADF00D, lat, dvc);
    wait_idle("t4b");
    do_req(1'b0, 32'hF000_0020, 32'h0, lat, dvc);

    // Reset with three entries held and the head stuck in a slow drain.
    mem_delay = 30;
    for (int i = 0; i < 3; i++) do_req(1'b1, 32'h400 + 32'(i * 4), $urandom, lat, dvc);
    chk("t5_count3", buf_count, 3);
    chk("t5_not_idle", idle, 0);
    rst = 1'b0;
    rst_cyc = cyc;
    #1;
    chk("t5_rst_count", buf_count, 0);
    chk("t5_rst_idle", idle, 1);
    chk("t5_rst_write_err", write_err, 0);
    chk("t5_rst_mem_trans", mem_trans, 0);
    chk("t5_rst_mem_addr", mem_addr, 0);
    chk("t5_rst_mem_wdata", mem_wdata, 0);
    chk("t5_rst_mem_write", mem_write, 0);
    chk("t5_rst_mem_side", {mem_size, mem_prot}, 0);
    mem_q.delete();
    ref_mem = tb_mem;
    ref_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("t5_stale_dv_seen", last_dv_cyc > rst_cyc, 1);
    chk("t5_count_after_stale", buf_count, 0);
    chk("t5_idle_after_stale", idle, 1);
    mem_delay = 0;
    do_req(1'b0, 32'h400, 32'h0, lat, dvc);
    wait_idle("t5");

    // Randomized mix of reads, writes, aborts and idle/busy gaps.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      ra = (k == 9) ? 32'hF000_0100 : 32'h300 + 32'(4 * $urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), ra, $urandom, lat, dvc);
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 4));
    end
    wait_idle("rand");
    repeat (5) @(posedge clk); #1;
    chk("end_mem_q_empty", mem_q.size(), 0);
    chk("end_cpu_q_empty", cpu_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_buffer_bridge.md
Name: write_buffer_bridge

Overview:
- Sits between the processor memory interface and memory_controller.
- Posts processor writes into a DEPTH-entry FIFO and acknowledges them immediately.
- Drains buffered writes to memory in order, one at a time.
- Services reads only once the buffer is empty, so memory ordering is strict.

Parameters:
DEPTH, 4, write-buffer entries; power of two, >= 2
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset; asynchronous and active-low (asserted when 0)
cpu_addr  input  ADDR_W  processor request address
cpu_wdata  input  DATA_W  processor write data
cpu_write  input  1  1 = write, 0 = read
cpu_size  input  1  access size, carried through unchanged
cpu_prot  input  2  protection bits, carried through unchanged
cpu_trans  input  2  00 idle, 01 busy, 10 nonseq, 11 seq; request valid when cpu_trans[1]=1
cpu_rdata  output  DATA_W  read data, valid when cpu_data_valid=1
cpu_data_valid  output  1  one-cycle completion pulse, for both reads and posted writes
cpu_abort  output  1  read aborted; qualified by cpu_data_valid
mem_addr  output  ADDR_W  to memory_controller
mem_wdata  output  DATA_W  to memory_controller
mem_write  output  1  to memory_controller
mem_size  output  1  to memory_controller
mem_prot  output  2  to memory_controller
mem_trans  output  2  to memory_controller
mem_rdata  input  DATA_W  from memory_controller
mem_data_valid  input  1  from memory_controller; high the cycle after a sampled request
mem_abort  input  1  from memory_controller
buf_count  output  log2(DEPTH)+1  current occupancy
write_err  output  1  sticky: a drained write returned mem_abort
idle  output  1  buffer empty, FSM in IDLE, no read pending

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; buffered writes are discarded.
  - FSM goes to IDLE; any in-flight memory access is abandoned.
  - All outputs are 0, except idle, which is 1.
  - A stale mem_data_valid arriving after reset deasserts is ignored, because the FSM is in IDLE.
- All outputs are registered.
- The processor holds its request stable until it sees cpu_data_valid.
- No request is accepted in a cycle where cpu_data_valid=1. This prevents double acceptance.
- Write accept (cycle N): requires cpu_trans[1]=1, cpu_write=1 and buf_count<DEPTH.
  - addr, wdata, size and prot are enqueued at the end of N.
  - cpu_data_valid=1 and cpu_abort=0 in N+1.
- Full (buf_count=DEPTH): writes stall with no response until an entry pops.
- Read accept (cycle N): requires cpu_trans[1]=1, cpu_write=0, buf_count=0, FSM in IDLE, and no enqueue in N.
  - Otherwise the read waits.
- FSM states:
  - IDLE
    - If buf_count>0, the head entry is issued: mem_trans=10 and mem_write=1 for one cycle, then go to WR_WAIT.
    - Else, if a read is accepted: issue mem_trans=10 and mem_write=0 in N+1, then go to RD_WAIT.
    - Drains always take priority over reads.
  - WR_WAIT
    - mem_trans=00 while waiting for mem_data_valid.
    - On mem_data_valid: pop the head; set write_err if mem_abort=1; return to IDLE.
    - The next drain is issued no earlier than the following cycle.
  - RD_WAIT
    - mem_trans=00 while waiting.
    - On mem_data_valid: capture mem_rdata and mem_abort; go to RD_RESP.
  - RD_RESP
    - cpu_rdata valid, cpu_data_valid=1, cpu_abort = captured abort, for one cycle; then IDLE.
    - Read latency: accept in N gives response in N+3 (mem_data_valid arrives in N+2).
- Enqueue and pop in the same cycle: buf_count is unchanged; pointers wrap modulo DEPTH.
- Memory-side fields are driven only while mem_trans=10; otherwise they hold their last values.
- write_err clears only on reset.
- cpu_trans=01 (busy) is treated as idle.

Test Plan:
- Write 0xDEADBEEF to 0x100 with the buffer empty -> cpu_data_valid in N+1; buf_count 1 then 0; memory sees mem_trans=10, addr 0x100, mem_write=1; memory word at 0x100 reads back 0xDEADBEEF.
- Five back-to-back writes to 0x0,0x4,0x8,0xC,0x10 with DEPTH=4 -> buf_count reaches 4 and the fifth write stalls until the first pop; memory receives the writes in issue order.
- Write 0x11223344 to 0x200, then immediately read 0x200 -> read waits for the drain; cpu_rdata=0x11223344, with cpu_data_valid exactly 3 cycles after read accept.
- Drained write with mem_abort=1 -> write_err=1 and it stays set; a following read with mem_abort=1 -> cpu_abort=1 with cpu_data_valid.
- rst=0 while 3 entries are buffered and a drain is in WR_WAIT -> buf_count=0, idle=1, all memory-side outputs 0 immediately; the late mem_data_valid is ignored and no pop underflow occurs.
- Request held stable across its cpu_data_valid cycle -> accepted exactly once (one enqueue).
